// File: rtl/uart_prog_loader.sv
// Boot-time program loader: receives a little-endian word image over an 8N1 UART,
// writes it into instruction memory through a req/gnt port, and releases core reset when done.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 217,
  parameter int          ADDR_W       = 10,
  parameter int          DEPTH        = 1024,
  parameter logic [31:0] END_WORD     = 32'hFFFF_FFFF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              en_i,
  input  logic              uart_rx_i,
  output logic              ready_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  L_HALF     = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  L_FULL     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  L_CLK_ONE  = 1;
  localparam logic [ADDR_W:0]   L_DEPTH    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   L_CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] L_LAST     = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] L_ADDR_ONE = 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR} state_t;

  rx_state_t         r_rxState, w_rxNext;
  state_t            r_state, w_next;
  logic              r_rxMeta, r_rxSync, r_rxPrev;
  logic [CNT_W-1:0]  r_clkCnt;
  logic [2:0]        r_bitIdx;
  logic [7:0]        r_rxShift;
  logic [1:0]        r_byteCnt;
  logic [23:0]       r_wordBuf;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_wordCnt;

  logic              w_byteValid, w_frameErr;
  logic              w_accept, w_wordDone, w_grant, w_latch;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_cntAfter;

  // RX frame sequencing; the start bit is re-checked mid-bit to reject glitches
  always_comb begin
    w_rxNext    = r_rxState;
    w_byteValid = 1'b0;
    w_frameErr  = 1'b0;
    unique case (r_rxState)
      RX_IDLE:  if (r_rxPrev && !r_rxSync) w_rxNext = RX_START;
      RX_START: if (r_clkCnt == L_HALF) w_rxNext = r_rxSync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (r_clkCnt == L_FULL && r_bitIdx == 3'd7) w_rxNext = RX_STOP;
      RX_STOP: begin
        if (r_clkCnt == L_FULL) begin
          w_rxNext    = RX_IDLE;
          w_byteValid = r_rxSync;
          w_frameErr  = !r_rxSync;
        end
      end
      default:  w_rxNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rxMeta  <= 1'b1;
      r_rxSync  <= 1'b1;
      r_rxPrev  <= 1'b1;
      r_rxState <= RX_IDLE;
      r_clkCnt  <= '0;
      r_bitIdx  <= '0;
      r_rxShift <= '0;
    end else begin
      r_rxMeta  <= uart_rx_i;
      r_rxSync  <= r_rxMeta;
      r_rxPrev  <= r_rxSync;
      r_rxState <= w_rxNext;
      if (r_rxState != w_rxNext || r_clkCnt == L_FULL)
        r_clkCnt <= '0;
      else
        r_clkCnt <= r_clkCnt + L_CLK_ONE;
      if (r_rxState == RX_START)
        r_bitIdx <= '0;
      if (r_rxState == RX_DATA && r_clkCnt == L_FULL) begin
        r_rxShift <= {r_rxSync, r_rxShift[7:1]};
        r_bitIdx  <= r_bitIdx + 3'd1;
      end
    end
  end

  assign w_accept   = (r_state == S_RECV) || (r_state == S_WRITE);
  assign w_wordDone = w_accept && w_byteValid && (r_byteCnt == 2'd3);
  assign w_word     = {r_rxShift, r_wordBuf};
  assign w_grant    = (r_state == S_WRITE) && mem_gnt_i;
  assign w_cntAfter = w_grant ? (r_wordCnt + L_CNT_ONE) : r_wordCnt;

  // A word finishing in the same cycle a write is granted is handled as if back in RECV
  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    unique case (r_state)
      S_IDLE: w_next = en_i ? S_RECV : S_DONE;
      S_RECV: begin
        if (w_frameErr)
          w_next = S_ERR;
        else if (w_wordDone) begin
          if (w_word == END_WORD)
            w_next = S_DONE;
          else if (r_wordCnt == L_DEPTH)
            w_next = S_ERR;
          else begin
            w_next  = S_WRITE;
            w_latch = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (w_frameErr)
          w_next = S_ERR;
        else if (w_wordDone) begin
          if (!mem_gnt_i)
            w_next = S_ERR;
          else if (w_word == END_WORD)
            w_next = S_DONE;
          else if (w_cntAfter == L_DEPTH)
            w_next = S_ERR;
          else begin
            w_next  = S_WRITE;
            w_latch = 1'b1;
          end
        end else if (mem_gnt_i)
          w_next = S_RECV;
      end
      S_DONE:  w_next = S_DONE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_byteCnt <= '0;
      r_wordBuf <= '0;
      r_wdata   <= '0;
      r_addr    <= '0;
      r_wordCnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept && w_byteValid) begin
        r_byteCnt <= r_byteCnt + 2'd1;
        unique case (r_byteCnt)
          2'd0:    r_wordBuf[7:0]   <= r_rxShift;
          2'd1:    r_wordBuf[15:8]  <= r_rxShift;
          2'd2:    r_wordBuf[23:16] <= r_rxShift;
          default: r_wordBuf        <= r_wordBuf;
        endcase
      end
      if (w_latch)
        r_wdata <= w_word;
      if (w_grant) begin
        r_wordCnt <= r_wordCnt + L_CNT_ONE;
        if (r_addr != L_LAST)
          r_addr <= r_addr + L_ADDR_ONE;
      end
    end
  end

  assign ready_o     = w_accept;
  assign mem_req_o   = (r_state == S_WRITE);
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign core_rst_o  = (r_state != S_DONE);
  assign done_o      = (r_state == S_DONE);
  assign err_o       = (r_state == S_ERR);
  assign word_cnt_o  = r_wordCnt;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and compares each granted memory write.
module tb_uart_prog_loader;

  localparam int CPB    = 4;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b1;
  logic              rx = 1'b1;
  logic              gnt = 1'b1;
  logic              ready, req, coreRst, done, err;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [ADDR_W:0]   wordCnt;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t expQ[$];
  int  compared = 0;
  int  mismatched = 0;
  bit  sawReady, sawReq;

  always #5 clk = ~clk;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .END_WORD(32'hFFFF_FFFF)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en), .uart_rx_i(rx),
    .ready_o(ready), .mem_req_o(req), .mem_addr_o(addr), .mem_wdata_o(wdata),
    .mem_gnt_i(gnt), .core_rst_o(coreRst), .done_o(done), .err_o(err),
    .word_cnt_o(wordCnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expectWrite(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  // one 8N1 frame, LSB first; goodStop=0 drives a broken stop bit
  task automatic applyStimulus(input logic [7:0] b, input logic goodStop);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = goodStop;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (2) tick();
  endtask

  task automatic sendWord(input logic [31:0] w);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(v[7:0], 1'b1);
      v = v >> 8;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 32'(ready), 32'd0);
    checkOutput({tag, "_req"}, 32'(req), 32'd0);
    checkOutput({tag, "_addr"}, 32'(addr), 32'd0);
    checkOutput({tag, "_wdata"}, wdata, 32'd0);
    checkOutput({tag, "_core_rst"}, 32'(coreRst), 32'd1);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_word_cnt"}, 32'(wordCnt), 32'd0);
  endtask

  task automatic applyReset(input logic enVal, input logic gntVal, input string tag);
    rx  = 1'b1;
    en  = enVal;
    gnt = gntVal;
    rst = 1'b1;
    repeat (2) tick();
    checkResetValues(tag);
    expQ.delete();
    sawReady = 1'b0;
    sawReq   = 1'b0;
    rst = 1'b0;
  endtask

  task automatic waitFlag(input bit wantDone, input int maxCycles, input string name);
    int n;
    n = 0;
    while (!(wantDone ? done : err) && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(wantDone ? done : err), 32'd1);
  endtask

  // monitor: every granted write must match the head of the expected queue
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ready) sawReady = 1'b1;
        if (req)   sawReq   = 1'b1;
        if (req && gnt) begin
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_write: got addr %0d data 0x%08h, expected no write", addr, wdata);
          end else begin
            wr_t e;
            e = expQ.pop_front();
            checkOutput("write_addr", 32'(addr), 32'(e.addr));
            checkOutput("write_data", wdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [ADDR_W-1:0] capAddr;
    logic [31:0]       capData;
    bit                stable;
    int                n;

    // basic two-word load followed by the terminator
    applyReset(1'b1, 1'b1, "rst_basic");
    tick();
    checkOutput("basic_ready", 32'(ready), 32'd1);
    expectWrite(10'd0, 32'h1234_5678);
    expectWrite(10'd1, 32'hDEAD_BEEF);
    sendWord(32'h1234_5678);
    sendWord(32'hDEAD_BEEF);
    sendWord(32'hFFFF_FFFF);
    waitFlag(1'b1, 20, "basic_done");
    checkOutput("basic_word_cnt", 32'(wordCnt), 32'd2);
    checkOutput("basic_core_rst", 32'(coreRst), 32'd0);
    checkOutput("basic_err", 32'(err), 32'd0);
    checkOutput("basic_ready_off", 32'(ready), 32'd0);
    checkOutput("basic_pending", 32'(expQ.size()), 32'd0);

    // loader disabled: straight to DONE
    applyReset(1'b0, 1'b1, "rst_disabled");
    repeat (2) tick();
    checkOutput("dis_done", 32'(done), 32'd1);
    checkOutput("dis_core_rst", 32'(coreRst), 32'd0);
    repeat (10) tick();
    checkOutput("dis_saw_ready", 32'(sawReady), 32'd0);
    checkOutput("dis_saw_req", 32'(sawReq), 32'd0);

    // grant stall of 20 cycles
    applyReset(1'b1, 1'b0, "rst_stall");
    tick();
    expectWrite(10'd0, 32'h0000_0005);
    expectWrite(10'd1, 32'h0000_000A);
    sendWord(32'h0000_0005);
    n = 0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    checkOutput("stall_req", 32'(req), 32'd1);
    capAddr = addr;
    capData = wdata;
    stable  = 1'b1;
    repeat (20) begin
      tick();
      if (!req || addr !== capAddr || wdata !== capData) stable = 1'b0;
    end
    checkOutput("stall_stable", 32'(stable), 32'd1);
    checkOutput("stall_addr", 32'(capAddr), 32'd0);
    checkOutput("stall_data", capData, 32'h0000_0005);
    gnt = 1'b1;
    repeat (2) tick();
    checkOutput("stall_req_drop", 32'(req), 32'd0);
    checkOutput("stall_cnt1", 32'(wordCnt), 32'd1);
    sendWord(32'h0000_000A);
    repeat (8) tick();
    checkOutput("stall_cnt2", 32'(wordCnt), 32'd2);
    checkOutput("stall_pending", 32'(expQ.size()), 32'd0);

    // framing error on the second byte
    applyReset(1'b1, 1'b1, "rst_frame");
    tick();
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b0);
    waitFlag(1'b0, 20, "frame_err");
    checkOutput("frame_core_rst", 32'(coreRst), 32'd1);
    checkOutput("frame_word_cnt", 32'(wordCnt), 32'd0);

    // overrun: second word completes while the first is still ungranted
    applyReset(1'b1, 1'b0, "rst_overrun");
    tick();
    sendWord(32'h0102_0304);
    sendWord(32'h0A0B_0C0D);
    waitFlag(1'b0, 20, "overrun_err");
    checkOutput("overrun_req", 32'(req), 32'd0);
    checkOutput("overrun_core_rst", 32'(coreRst), 32'd1);
    checkOutput("overrun_word_cnt", 32'(wordCnt), 32'd0);

    // capacity: third word with DEPTH=2
    applyReset(1'b1, 1'b1, "rst_capacity");
    tick();
    expectWrite(10'd0, 32'h1111_1111);
    expectWrite(10'd1, 32'h2222_2222);
    sendWord(32'h1111_1111);
    sendWord(32'h2222_2222);
    sendWord(32'h3333_3333);
    waitFlag(1'b0, 20, "capacity_err");
    checkOutput("capacity_word_cnt", 32'(wordCnt), 32'd2);
    checkOutput("capacity_done", 32'(done), 32'd0);
    checkOutput("capacity_pending", 32'(expQ.size()), 32'd0);

    // reset asserted in the middle of the third byte, then a clean reload
    applyReset(1'b1, 1'b1, "rst_mid_pre");
    tick();
    applyStimulus(8'hAA, 1'b1);
    applyStimulus(8'hBB, 1'b1);
    rx = 1'b0;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    checkResetValues("midrst");
    applyReset(1'b1, 1'b1, "rst_mid_post");
    tick();
    expectWrite(10'd0, 32'hCAFE_F00D);
    sendWord(32'hCAFE_F00D);
    sendWord(32'hFFFF_FFFF);
    waitFlag(1'b1, 20, "reload_done");
    checkOutput("reload_word_cnt", 32'(wordCnt), 32'd1);
    checkOutput("reload_err", 32'(err), 32'd0);
    checkOutput("reload_pending", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Boot-time program loader in the user project area.
- Receives a program image over a UART pin (mprj_io[5]) after advertising readiness on mprj_io[37].
- Assembles little-endian 32-bit words and writes them to the BrqRV_EB1 instruction memory through a req/gnt port, holding the core in reset until the image is complete.
- Sequences the memory write datapath and gates core start-up.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per UART bit (>=4); sample point is CLKS_PER_BIT/2.
- ADDR_W, 10, word-address width of the instruction memory.
- DEPTH, 1024, maximum number of words accepted (<= 2**ADDR_W).
- END_WORD, 32'hFFFF_FFFF, terminator word; it ends loading and is never written.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- en_i  in  1  loader enable, sampled in IDLE; 0 boots the core without loading.
- uart_rx_i  in  1  UART serial input, idle high, 8N1, LSB first.
- ready_o  out  1  loader is accepting bytes; drives mprj_io[37].
- mem_req_o  out  1  write request to instruction memory.
- mem_addr_o  out  ADDR_W  word address of the write.
- mem_wdata_o  out  32  write data.
- mem_gnt_i  in  1  memory accepts the write in the cycle where req and gnt are both 1.
- core_rst_o  out  1  active-high reset to the core.
- done_o  out  1  loading completed successfully.
- err_o  out  1  sticky error (framing, overrun or capacity).
- word_cnt_o  out  ADDR_W+1  number of words written.

Behaviour:
- Reset values:
  - ready_o=0, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0.
  - core_rst_o=1, done_o=0, err_o=0, word_cnt_o=0.
  - RX and byte counters cleared; state=IDLE.
- Reset asserted mid-load aborts everything immediately. No partial write completes after reset assertion.
- RX front end:
  - uart_rx_i passes through a 2-flop synchroniser.
  - A synchronised high-to-low transition while the RX is idle starts a frame.
  - Start bit is re-checked at CLKS_PER_BIT/2. If it is high, the frame is a glitch: return to RX idle with no error.
  - 8 data bits are then sampled at CLKS_PER_BIT intervals, followed by the stop bit.
  - Stop bit = 0 is a framing error and sends the FSM to ERR.
  - A byte-valid strobe pulses for 1 cycle at the stop-bit sample.
- Word assembly:
  - The first byte goes into bits [7:0], the fourth into [31:24].
  - On the 4th byte the word is complete; the byte count wraps to 0.
- FSM states:
  - IDLE:
    - en_i=0: go to DONE.
    - Otherwise go to RECV next cycle.
  - RECV (ready_o=1):
    - Complete word == END_WORD: go to DONE.
    - Else if word_cnt_o == DEPTH: go to ERR.
    - Else latch mem_wdata_o, go to WRITE.
  - WRITE (ready_o=1):
    - mem_req_o=1; addr and data stay stable until grant.
    - On req&gnt: mem_req_o drops the next cycle, mem_addr_o and word_cnt_o increment, return to RECV.
    - The RX keeps receiving during WRITE.
    - If a further word completes while WRITE is still pending, go to ERR (overrun).
  - DONE: core_rst_o=0, done_o=1, ready_o=0. Terminal until reset; all further RX activity is ignored.
  - ERR: err_o=1, core_rst_o=1, ready_o=0, mem_req_o=0. Terminal until reset.
- Latency: DONE is reached, and core_rst_o falls, 1 cycle after the stop-bit sample of the last END_WORD byte.
- mem_addr_o is never incremented past DEPTH-1 as a write address.

Test Plan:
- CLKS_PER_BIT=4, en_i=1; send bytes 78 56 34 12 EF BE AD DE, then FF FF FF FF; gnt tied 1:
  - writes 0x12345678 @0 and 0xDEADBEEF @1;
  - word_cnt_o=2; done_o=1; core_rst_o=0; err_o=0.
- en_i=0 out of reset:
  - DONE within 2 cycles; core_rst_o=0; ready_o never asserted; no mem_req_o.
- Stall: hold mem_gnt_i=0 for 20 cycles after req for word 0x00000005:
  - req/addr/data stable throughout;
  - single write on gnt;
  - next word 0x0000000A lands at address 1.
- Framing error: stop bit driven 0 on the 2nd byte:
  - err_o=1; core_rst_o stays 1; no writes.
- Overrun: gnt held 0 while a second full word arrives:
  - err_o=1; mem_req_o=0.
- Capacity: DEPTH=2, send 3 non-terminator words:
  - 2 writes, then err_o=1.
- Reset mid-load: assert wb_rst_i during the 3rd byte:
  - all outputs return to reset values;
  - a fresh load afterwards succeeds from address 0.
